// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Instruction-memory read bus between the fetch unit and the
//               instruction memory.  Request/acknowledge protocol.  The
//               request and address are held until the acknowledge arrives.
// Revision    : 1.0  initial release
// ============================================================================
interface if_fetch_unit_if #(
  parameter int IMEM_AW = 32
) ();

  logic               imem_req_o;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic               imem_ack_i;
  logic [31:0]        imem_rdata_i;

  // Fetch unit side: issues requests, receives data.
  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  // Memory side: answers requests.
  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );

endinterface : if_fetch_unit_if
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage.  Issues one outstanding read per PC
//               value, buffers returned words in a small FIFO and presents
//               the head as {valid, instr, pc+4}.  Holds the PC register
//               while no fetch for its current value has been issued.
// Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
  parameter int DEPTH   = 2,   // FIFO entries, power of two, >= 2
  parameter int IMEM_AW = 32   // instruction-memory address width
) (
  input  wire              clk_i,
  input  wire              rst_i,       // asynchronous, active low
  input  wire              start_i,
  input  wire [31:0]       pc_i,
  input  wire              flush_i,
  input  wire              id_stall_i,
  output logic             pc_stall_o,
  if_fetch_unit_if.master  imem,
  output logic             if_valid_o,
  output logic [31:0]      if_instr_o,
  output logic [31:0]      if_pc4_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  // --------------------------------------------------------------------------
  // Control FSM states
  //   S_OFF     : run enable low
  //   S_READY   : running, nothing outstanding
  //   S_WAIT    : request outstanding, its data will be kept
  //   S_DISCARD : request outstanding, its data will be dropped
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_READY   = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t              r_state;

  // Memory request registers
  logic                r_req;
  logic [IMEM_AW-1:0]  r_addr;

  // Instruction FIFO storage and bookkeeping
  logic [31:0]         r_mem_instr [DEPTH];
  logic [31:0]         r_mem_pc4   [DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;

  // Registered view of the FIFO head
  logic                r_valid;
  logic [31:0]         r_instr;
  logic [31:0]         r_pc4;

  // Combinational control
  logic                w_running;
  logic                w_ack;
  logic                w_push;
  logic                w_pop;
  logic                w_clear;
  logic                w_issue;
  logic [c_cnt_w-1:0]  w_cnt_after_pop;
  logic [c_cnt_w-1:0]  w_cnt_nxt;
  logic [c_ptr_w-1:0]  w_rd_ptr_nxt;
  logic [IMEM_AW-1:0]  w_pc_addr;
  logic [31:0]         w_req_pc;
  logic [31:0]         w_push_pc4;

  // --------------------------------------------------------------------------
  // Width adaptation between the 32-bit PC and the memory address bus.
  // The address is zero-extended or truncated; the FIFO always keeps a
  // 32-bit PC+4 derived from the registered request address.
  // --------------------------------------------------------------------------
  generate
    if (IMEM_AW == 32) begin : g_addr_eq
      assign w_pc_addr = pc_i;
      assign w_req_pc  = r_addr;
    end else if (IMEM_AW > 32) begin : g_addr_wide
      assign w_pc_addr = {{(IMEM_AW-32){1'b0}}, pc_i};
      assign w_req_pc  = r_addr[31:0];
    end else begin : g_addr_narrow
      assign w_pc_addr = pc_i[IMEM_AW-1:0];
      assign w_req_pc  = {{(32-IMEM_AW){1'b0}}, r_addr};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Handshake and FIFO occupancy arithmetic
  // --------------------------------------------------------------------------
  assign w_running       = (r_state != S_OFF);
  // An acknowledge only means something while a request is outstanding.
  assign w_ack           = imem.imem_ack_i & r_req;
  // Only a kept request writes the FIFO; DISCARD data is dropped here.
  assign w_push          = (r_state == S_WAIT) & imem.imem_ack_i;
  assign w_pop           = r_valid & ~id_stall_i & ~flush_i;
  // A redirect or the run enable dropping empties the buffer.
  assign w_clear         = flush_i | ~start_i;
  assign w_cnt_after_pop = r_count - c_cnt_w'(w_pop);
  assign w_cnt_nxt       = w_cnt_after_pop + c_cnt_w'(w_push);
  assign w_rd_ptr_nxt    = r_rd_ptr + c_ptr_w'(w_pop);
  assign w_push_pc4      = w_req_pc + 32'd4;

  // A new fetch is launched from READY, or back-to-back on the acknowledge
  // of a kept request, provided a FIFO slot is left for its data.
  assign w_issue = start_i & ~flush_i
                 & ((r_state == S_READY) | ((r_state == S_WAIT) & imem.imem_ack_i))
                 & (w_cnt_nxt < c_depth);

  // The PC may advance on issue, and must load the target on a redirect.
  assign pc_stall_o = w_running & ~flush_i & ~w_issue;

  // --------------------------------------------------------------------------
  // Control FSM together with the memory request/address registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_OFF;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      // Request and address are held stable until acknowledged.
      if (w_issue) begin
        r_req  <= 1'b1;
        r_addr <= w_pc_addr;
      end else if (w_ack) begin
        r_req  <= 1'b0;
      end

      case (r_state)
        S_OFF: begin
          // Nothing is issued in the cycle that leaves OFF.
          if (start_i) r_state <= S_READY;
        end
        S_READY: begin
          if (!start_i)     r_state <= S_OFF;
          else if (w_issue) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!start_i)                  r_state <= imem.imem_ack_i ? S_OFF   : S_DISCARD;
          else if (flush_i)              r_state <= imem.imem_ack_i ? S_READY : S_DISCARD;
          else if (imem.imem_ack_i)      r_state <= w_issue ? S_WAIT : S_READY;
        end
        S_DISCARD: begin
          // The stale request finishes here; its data never enters the FIFO.
          if (imem.imem_ack_i) r_state <= start_i ? S_READY : S_OFF;
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage: returned word and the PC+4 of the address that fetched it
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_push && !w_clear) begin
      r_mem_instr[r_wr_ptr] <= imem.imem_rdata_i;
      r_mem_pc4[r_wr_ptr]   <= w_push_pc4;
    end
  end

  // --------------------------------------------------------------------------
  // Registered FIFO head.  When the pop empties all older entries the head
  // comes straight from the bus; otherwise from storage.  When the FIFO goes
  // empty the instruction and PC+4 keep their last value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc4   <= '0;
    end else if (w_clear) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) begin
        if (w_cnt_after_pop == '0) begin
          r_instr <= imem.imem_rdata_i;
          r_pc4   <= w_push_pc4;
        end else begin
          r_instr <= r_mem_instr[w_rd_ptr_nxt];
          r_pc4   <= r_mem_pc4[w_rd_ptr_nxt];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign imem.imem_req_o  = r_req;
  assign imem.imem_addr_o = r_addr;
  assign if_valid_o       = r_valid;
  assign if_instr_o       = r_instr;
  assign if_pc4_o         = r_pc4;

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit.  Acts as PC register
//               and instruction memory, keeps a queue-based reference of the
//               fetch stage, and compares DUT outputs from a separate monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam int DEPTH = 2;
  localparam int AW    = 32;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } cyc_t;

  logic        clk_i      = 1'b0;
  logic        rst_i      = 1'b1;
  logic        start_i    = 1'b0;
  logic        flush_i    = 1'b0;
  logic        id_stall_i = 1'b0;
  logic [31:0] pc_i       = '0;
  logic        pc_stall_o;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc4_o;

  if_fetch_unit_if #(.IMEM_AW(AW)) imem ();

  if_fetch_unit #(.DEPTH(DEPTH), .IMEM_AW(AW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .pc_i       (pc_i),
    .flush_i    (flush_i),
    .id_stall_i (id_stall_i),
    .pc_stall_o (pc_stall_o),
    .imem       (imem),
    .if_valid_o (if_valid_o),
    .if_instr_o (if_instr_o),
    .if_pc4_o   (if_pc4_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference state: running flag, one outstanding request, a queue of
  // buffered entries, and the last head shown (outputs hold it when empty).
  bit          m_run, m_out, m_keep;
  logic [31:0] m_addr, m_last_instr, m_last_pc4, pc_reg;
  int          m_wait, m_lat;
  ent_t        m_q[$];
  cyc_t        sb_q[$];
  ent_t        deliv_q[$];

  // Stimulus knobs
  bit          k_start;
  int          k_stop, k_stall, k_flush, k_lat, k_spur;
  bit          f_once;
  logic [31:0] f_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_out = 0; m_keep = 0; m_addr = '0;
    m_last_instr = '0; m_last_pc4 = '0; m_wait = 0; m_lat = 1;
    m_q.delete(); sb_q.delete(); deliv_q.delete();
  endtask

  // One cycle of stimulus plus reference update; called just after posedge.
  task automatic body();
    bit          ack, valid, pop, done, push, issue;
    int          size_n;
    logic [31:0] tgt, rdata;
    cyc_t        rec;
    ent_t        e;

    start_i    = k_start && !($urandom_range(0, 99) < k_stop);
    flush_i    = f_once || ($urandom_range(0, 99) < k_flush);
    tgt        = $urandom() & 32'h0000_0FFC;
    if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF8;
    if (f_once) tgt = f_tgt;
    f_once     = 0;
    id_stall_i = ($urandom_range(0, 99) < k_stall);
    pc_i       = pc_reg;

    ack   = 0;
    rdata = $urandom();
    if (m_out) begin
      if (m_wait + 1 >= m_lat) begin
        ack   = 1;
        rdata = mem_word(m_addr);
      end
      m_wait++;
    end else if ($urandom_range(0, 99) < k_spur) begin
      ack = 1;
    end
    imem.imem_ack_i   = ack;
    imem.imem_rdata_i = rdata;

    valid     = (m_q.size() > 0);
    rec.req   = m_out;
    rec.addr  = m_addr;
    rec.valid = valid;
    rec.instr = valid ? m_q[0].instr : m_last_instr;
    rec.pc4   = valid ? m_q[0].pc4   : m_last_pc4;

    pop    = valid && !id_stall_i && !flush_i;
    done   = m_out && ack;
    push   = done && m_keep;
    size_n = m_q.size() + int'(push) - int'(pop);
    issue  = m_run && start_i && !flush_i && (!m_out || push) && (size_n < DEPTH);
    rec.stall = m_run && !flush_i && !issue;
    sb_q.push_back(rec);

    if (valid) begin
      m_last_instr = m_q[0].instr;
      m_last_pc4   = m_q[0].pc4;
    end
    if (pop) begin
      e = m_q.pop_front();
      deliv_q.push_back(e);
    end
    if (push) m_q.push_back('{mem_word(m_addr), m_addr + 32'd4});
    if (flush_i || !start_i) m_q.delete();

    if (issue) begin
      m_out = 1; m_keep = 1; m_addr = pc_i; m_wait = 0;
      m_lat = (k_lat > 0) ? k_lat : $urandom_range(1, 4);
    end else if (done) begin
      m_out = 0;
    end else if (m_out && (flush_i || !start_i)) begin
      m_keep = 0;
    end
    m_run  = start_i || m_out;
    pc_reg = flush_i ? tgt : (issue ? pc_reg + 32'd4 : pc_reg);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      body();
    end
  endtask

  // Asserts reset between clock edges and checks the immediate effect.
  task automatic assert_reset();
    rst_i = 1'b0;
    #1;
    chk("rst_req",   imem.imem_req_o,  32'd0);
    chk("rst_addr",  imem.imem_addr_o, 32'd0);
    chk("rst_valid", if_valid_o,       32'd0);
    chk("rst_instr", if_instr_o,       32'd0);
    chk("rst_pc4",   if_pc4_o,         32'd0);
    chk("rst_stall", pc_stall_o,       32'd0);
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    body();
  endtask

  // Monitor: compares every cycle's outputs and every consumed instruction.
  initial begin : monitor
    cyc_t rec;
    ent_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i && sb_q.size() > 0) begin
        rec = sb_q.pop_front();
        chk("pc_stall", pc_stall_o,       rec.stall);
        chk("req",      imem.imem_req_o,  rec.req);
        chk("addr",     imem.imem_addr_o, rec.addr);
        chk("valid",    if_valid_o,       rec.valid);
        chk("instr",    if_instr_o,       rec.instr);
        chk("pc4",      if_pc4_o,         rec.pc4);
        if (if_valid_o && !id_stall_i && !flush_i) begin
          if (deliv_q.size() == 0) begin
            chk("deliver_unexpected", 32'd1, 32'd0);
          end else begin
            e = deliv_q.pop_front();
            chk("deliver_instr", if_instr_o, e.instr);
            chk("deliver_pc4",   if_pc4_o,   e.pc4);
          end
        end
      end
    end
  end

  initial begin : stimulus
    imem.imem_ack_i   = 1'b0;
    imem.imem_rdata_i = '0;
    pc_reg = '0;
    k_start = 0; k_stop = 0; k_stall = 0; k_flush = 0; k_lat = 1; k_spur = 0;
    f_once = 0; f_tgt = '0;
    model_reset();

    #2;
    assert_reset();
    repeat (2) @(posedge clk_i);
    release_reset();

    // Straight-line fetch with a single-cycle memory
    k_start = 1; k_lat = 1;
    step(12);

    // Decode stalled: buffer fills, then drains in order
    k_stall = 100;
    step(10);
    k_stall = 0;
    step(8);

    // Redirect to 0x40 and run with a 3-cycle memory
    f_once = 1; f_tgt = 32'h40; k_lat = 3;
    step(14);

    // Redirect to 0x100 while a slow request is outstanding
    k_lat = 4;
    for (int i = 0; i < 10 && !m_out; i++) step(1);
    f_once = 1; f_tgt = 32'h100;
    step(12);

    // Redirect coincident with the acknowledge that would fill the FIFO
    k_lat = 1; k_stall = 100;
    for (int i = 0; i < 20; i++) begin
      if (m_q.size() == DEPTH - 1 && m_out) break;
      step(1);
    end
    f_once = 1; f_tgt = 32'h200;
    step(1);
    k_stall = 0;
    step(6);

    // Randomised traffic
    k_lat = 0; k_stall = 30; k_flush = 8; k_spur = 10; k_stop = 3;
    step(1500);

    // Asynchronous reset with a request outstanding, then stale acknowledges
    k_flush = 0; k_stop = 0; k_stall = 0; k_spur = 0; k_lat = 3;
    for (int i = 0; i < 20 && !m_out; i++) step(1);
    @(posedge clk_i); #3;
    assert_reset();
    repeat (2) @(posedge clk_i);
    k_start = 0; k_spur = 100;
    release_reset();
    step(1);
    k_start = 1;
    step(1);
    k_spur = 0; k_lat = 1;
    step(20);

    // More randomised traffic after reset
    k_lat = 0; k_stall = 25; k_flush = 6; k_spur = 10; k_stop = 2;
    step(400);

    @(negedge clk_i); #1;
    chk("scoreboard_drain", sb_q.size(),    32'd0);
    chk("delivery_drain",   deliv_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_if_fetch_unit
`default_nettype wire
